// File: rtl/serial_addsub_if.sv
// Handshake/operand bundle for serial_addsub.
// The ovf line exists only when SERIAL_ADDSUB_OVF_EN is defined.
interface serial_addsub_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             busy;
  logic             done;
`ifdef SERIAL_ADDSUB_OVF_EN
  logic             ovf;

  modport master (output start, sub, a, b, input result, cout, busy, done, ovf);
  modport slave  (input start, sub, a, b, output result, cout, busy, done, ovf);
`else
  modport master (output start, sub, a, b, input result, cout, busy, done);
  modport slave  (input start, sub, a, b, output result, cout, busy, done);
`endif
endinterface

// File: rtl/serial_addsub.sv
// serial_addsub: multi-cycle adder/subtractor. WIDTH-bit operands are
// consumed DIGIT bits per clock, LSB first, through a DIGIT-wide ripple of
// add/sub cells with a registered carry/borrow between digits.
// Optional signed-overflow output: define SERIAL_ADDSUB_OVF_EN.

// One full-adder / full-subtractor bit cell; sub selects the borrow form.
module serial_addsub_cell (
  input  logic x,
  input  logic y,
  input  logic ci,
  input  logic sub,
  output logic s,
  output logic co
);
  // Sum and difference share the same xor; only carry vs borrow differs.
  always_comb begin
    s  = x ^ y ^ ci;
    co = sub ? ((~x & y) | (y & ci) | (ci & ~x))
             : ((x & y)  | (y & ci) | (ci & x));
  end
endmodule

module serial_addsub #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic            clk,
  input  logic            rst,
  serial_addsub_if.slave  io
);
  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = $clog2(NDIG + 1);

  if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_cfg
    $error("serial_addsub: WIDTH must be >= 2 and a multiple of DIGIT");
  end

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             cy_q, cy_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             sub_q, sub_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             cout_q, cout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
`ifdef SERIAL_ADDSUB_OVF_EN
  logic             am_q, am_d;
  logic             bm_q, bm_d;
  logic             ovf_q, ovf_d;
`endif

  // Digit datapath: ripple from the registered carry through DIGIT cells.
  logic [DIGIT:0]   c;
  logic [DIGIT-1:0] dres;
  assign c[0] = cy_q;

  for (genvar i = 0; i < DIGIT; i++) begin : g_cell
    serial_addsub_cell u_cell (
      .x   (a_q[i]),
      .y   (b_q[i]),
      .ci  (c[i]),
      .sub (sub_q),
      .s   (dres[i]),
      .co  (c[i+1])
    );
  end

  // Next-state logic: accept in IDLE/DONE, step one digit per RUN cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cy_d    = cy_q;
    a_d     = a_q;
    b_d     = b_q;
    sub_d   = sub_q;
    res_d   = res_q;
    cout_d  = cout_q;
`ifdef SERIAL_ADDSUB_OVF_EN
    am_d    = am_q;
    bm_d    = bm_q;
    ovf_d   = ovf_q;
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        if (io.start) begin
          state_d = S_RUN;
          a_d     = io.a;
          b_d     = io.b;
          sub_d   = io.sub;
          cy_d    = 1'b0;
          cnt_d   = '0;
`ifdef SERIAL_ADDSUB_OVF_EN
          am_d    = io.a[WIDTH-1];
          bm_d    = io.b[WIDTH-1];
`endif
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        // New digit enters at the MSB end; after NDIG steps it is in place.
        a_d   = a_q >> DIGIT;
        b_d   = b_q >> DIGIT;
        res_d = (res_q >> DIGIT) | (WIDTH'(dres) << (WIDTH - DIGIT));
        cy_d  = c[DIGIT];
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(NDIG - 1)) begin
          state_d = S_DONE;
          cout_d  = c[DIGIT];
`ifdef SERIAL_ADDSUB_OVF_EN
          // dres MSB is the final result MSB on the last digit.
          ovf_d   = sub_q ? ((am_q != bm_q) & (dres[DIGIT-1] != am_q))
                          : ((am_q == bm_q) & (dres[DIGIT-1] != am_q));
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d == S_RUN);
    done_d = (state_d == S_DONE);
  end

  // State and registered outputs; reset abandons any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      cy_q    <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sub_q   <= 1'b0;
      res_q   <= '0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SERIAL_ADDSUB_OVF_EN
      am_q    <= 1'b0;
      bm_q    <= 1'b0;
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cy_q    <= cy_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sub_q   <= sub_d;
      res_q   <= res_d;
      cout_q  <= cout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef SERIAL_ADDSUB_OVF_EN
      am_q    <= am_d;
      bm_q    <= bm_d;
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign io.result = res_q;
  assign io.cout   = cout_q;
  assign io.busy   = busy_q;
  assign io.done   = done_q;
`ifdef SERIAL_ADDSUB_OVF_EN
  assign io.ovf    = ovf_q;
`endif
endmodule

// File: tb/tb_serial_addsub.sv
// Bench for serial_addsub: DUT 0 is WIDTH=8/DIGIT=1, DUT 1 is WIDTH=8/DIGIT=4.
// Expected values come from plain integer arithmetic on the operands.
module tb_serial_addsub;
  logic clk;
  logic rst;

  logic       st [2];
  logic       sb [2];
  logic [7:0] aa [2];
  logic [7:0] bb [2];
  logic [7:0] res[2];
  logic       co [2];
  logic       bz [2];
  logic       dn [2];
  logic       ov [2];

  int checks   = 0;
  int failures = 0;

  serial_addsub_if #(.WIDTH(8)) if0 ();
  serial_addsub_if #(.WIDTH(8)) if1 ();

  assign if0.start = st[0];
  assign if0.sub   = sb[0];
  assign if0.a     = aa[0];
  assign if0.b     = bb[0];
  assign if1.start = st[1];
  assign if1.sub   = sb[1];
  assign if1.a     = aa[1];
  assign if1.b     = bb[1];
  assign res[0] = if0.result;
  assign co[0]  = if0.cout;
  assign bz[0]  = if0.busy;
  assign dn[0]  = if0.done;
  assign res[1] = if1.result;
  assign co[1]  = if1.cout;
  assign bz[1]  = if1.busy;
  assign dn[1]  = if1.done;
`ifdef SERIAL_ADDSUB_OVF_EN
  assign ov[0] = if0.ovf;
  assign ov[1] = if1.ovf;
`else
  assign ov[0] = 1'b0;
  assign ov[1] = 1'b0;
`endif

  serial_addsub #(.WIDTH(8), .DIGIT(1)) u_dut0 (.clk(clk), .rst(rst), .io(if0));
  serial_addsub #(.WIDTH(8), .DIGIT(4)) u_dut1 (.clk(clk), .rst(rst), .io(if1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int ndig(input int d);
    return (d == 0) ? 8 : 2;
  endfunction

  // {ovf, cout, result} from integer arithmetic.
  function automatic logic [9:0] model(input logic s, input logic [7:0] x, input logic [7:0] y);
    int ux, uy, sx, sy, u, sv;
    logic [7:0] r;
    logic c, v;
    ux = int'(x);
    uy = int'(y);
    sx = (ux > 127) ? ux - 256 : ux;
    sy = (uy > 127) ? uy - 256 : uy;
    if (s) begin
      u  = ux - uy;
      c  = (ux < uy);
      sv = sx - sy;
    end else begin
      u  = ux + uy;
      c  = (u > 255);
      sv = sx + sy;
    end
    r = u[7:0];
    v = (sv > 127) || (sv < -128);
    return {v, c, r};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One operation; called at a negedge with the DUT idle.
  // mode 0: plain, 1: spurious start mid-RUN, 2: reset mid-RUN.
  task automatic op(input int d, input logic s, input logic [7:0] x, input logic [7:0] y,
                    input int mode);
    int n, k, nb, kd;
    logic [9:0] e;
    bit seen;
    n = ndig(d);
    e = model(s, x, y);
    st[d] = 1'b1; sb[d] = s; aa[d] = x; bb[d] = y;
    k = 0; nb = 0; kd = 0;
    while (kd == 0 && k < n + 4) begin
      @(negedge clk);
      k++;
      if (bz[d]) nb++;
      if (dn[d]) kd = k;
      if (k == 1) begin
        st[d] = 1'b0; aa[d] = 8'($urandom); bb[d] = 8'($urandom); sb[d] = 1'($urandom);
      end
      if (mode == 1 && k == 3) begin
        st[d] = 1'b1; aa[d] = 8'($urandom); bb[d] = 8'($urandom); sb[d] = ~s;
      end
      if (mode == 1 && k == 4) st[d] = 1'b0;
      if (mode == 2 && k == 3) begin
        chk("busy_before_rst", 32'(bz[d]), 32'd1);
        #2 rst = 1'b1;
        #1 chk("async_rst_out", {bz[d], dn[d], co[d], ov[d], res[d]}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        repeat (n + 3) begin
          @(negedge clk);
          if (dn[d] || bz[d]) seen = 1'b1;
        end
        chk("no_done_after_rst", 32'(seen), 32'd0);
        return;
      end
    end
    chk("done_latency", 32'(kd), 32'(n + 1));
    chk("busy_cycles", 32'(nb), 32'(n));
    chk("result", 32'(res[d]), 32'(e[7:0]));
    chk("cout", 32'(co[d]), 32'(e[8]));
`ifdef SERIAL_ADDSUB_OVF_EN
    chk("ovf", 32'(ov[d]), 32'(e[9]));
`endif
    @(negedge clk);
    chk("done_one_pulse", 32'(dn[d]), 32'd0);
    chk("result_hold", {co[d], res[d]}, {e[8], e[7:0]});
  endtask

  // start held high; a fresh operand pair each time one is accepted.
  task automatic b2b(input int d);
    int n, k, last, j;
    logic [7:0] xa[5];
    logic [7:0] xb[5];
    logic       xs[5];
    logic [9:0] e;
    n = ndig(d);
    for (int i = 0; i < 5; i++) begin
      xa[i] = 8'($urandom); xb[i] = 8'($urandom); xs[i] = 1'($urandom);
    end
    st[d] = 1'b1; sb[d] = xs[0]; aa[d] = xa[0]; bb[d] = xb[0];
    k = 0; last = 0; j = 0;
    while (j < 5 && k < 80) begin
      @(negedge clk);
      k++;
      if (dn[d]) begin
        e = model(xs[j], xa[j], xb[j]);
        chk("b2b_result", 32'(res[d]), 32'(e[7:0]));
        chk("b2b_cout", 32'(co[d]), 32'(e[8]));
`ifdef SERIAL_ADDSUB_OVF_EN
        chk("b2b_ovf", 32'(ov[d]), 32'(e[9]));
`endif
        chk("b2b_period", 32'(k - last), 32'(n + 1));
        last = k;
        j++;
        if (j < 5) begin
          sb[d] = xs[j]; aa[d] = xa[j]; bb[d] = xb[j];
        end else begin
          st[d] = 1'b0;
        end
      end
    end
    chk("b2b_count", 32'(j), 32'd5);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      st[i] = 1'b0; sb[i] = 1'b0; aa[i] = '0; bb[i] = '0;
    end
    repeat (2) @(negedge clk);
    chk("reset_out0", {bz[0], dn[0], co[0], ov[0], res[0]}, 32'd0);
    chk("reset_out1", {bz[1], dn[1], co[1], ov[1], res[1]}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_out0", {bz[0], dn[0], co[0], ov[0], res[0]}, 32'd0);

    op(0, 1'b0, 8'h5A, 8'h3C, 0);
    op(0, 1'b0, 8'hFF, 8'h01, 0);
    op(0, 1'b1, 8'h10, 8'h20, 0);
    op(0, 1'b1, 8'h20, 8'h10, 0);
    op(1, 1'b1, 8'h80, 8'h01, 0);
    op(1, 1'b0, 8'hFF, 8'hFF, 0);
    op(1, 1'b1, 8'h00, 8'h00, 0);
    op(0, 1'b0, 8'h33, 8'h44, 1);
    op(0, 1'b0, 8'h12, 8'h34, 2);
    op(0, 1'b1, 8'h00, 8'h01, 0);
    b2b(0);
    b2b(1);
    for (int i = 0; i < 12; i++) begin
      op(i % 2, 1'($urandom), 8'($urandom), 8'($urandom), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute bound so the run always terminates.
  initial begin
    #200000;
    failures++;
    $display("FAIL timeout checks=%0d", checks);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end
endmodule
